// File: rtl/imm_pkg.sv
// Shared definitions for the immediate encoder: format codes, opcodes,
// the NOP word and the load-immediate range bounds.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_SB = 3'd2,
    FMT_U  = 3'd3,
    FMT_UJ = 3'd4,
    FMT_LI = 3'd5
  } imm_fmt_t;

  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_ADDI  = 7'b0010011;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Largest LI value whose rounded-up upper part still fits a positive LUI.
  localparam logic signed [63:0] LI_MIN = -64'sd2147483648;
  localparam logic signed [63:0] LI_MAX = 64'sh7FFF_F7FF;

  // True when v equals the sign extension of its low n bits.
  function automatic logic fits_s(input logic [63:0] v, input int unsigned n);
    logic [63:0] ext;
    ext = $unsigned($signed(v << (64 - n)) >>> (64 - n));
    return ext == v;
  endfunction

endpackage

// File: rtl/imm_fmt_pack.sv
// Combinational packer: scatters an immediate into the I/S/SB/U/UJ bit
// positions of a template word and flags values that do not fit.
module imm_fmt_pack
  import imm_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] tmpl,
  input  logic [63:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  // Template bits 31:25 are immediate positions in every supported format.
  logic unused_tmpl;
  assign unused_tmpl = ^tmpl[31:25];

  always_comb begin
    inst = NOP_INST;
    err  = 1'b1;
    case (fmt)
      FMT_I: begin
        inst = {imm[11:0], tmpl[19:0]};
        err  = !fits_s(imm, 12);
      end
      FMT_S: begin
        inst = {imm[11:5], tmpl[24:12], imm[4:0], tmpl[6:0]};
        err  = !fits_s(imm, 12);
      end
      FMT_SB: begin
        inst = {imm[12], imm[10:5], tmpl[24:12], imm[4:1], imm[11], tmpl[6:0]};
        err  = !fits_s(imm, 13) || imm[0];
      end
      FMT_U: begin
        inst = {imm[31:12], tmpl[11:0]};
        err  = !fits_s(imm, 32) || (imm[11:0] != 12'd0);
      end
      FMT_UJ: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], tmpl[11:0]};
        err  = !fits_s(imm, 21) || imm[0];
      end
      default: begin
        inst = NOP_INST;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder with valid/ready handshake and registered output;
// load-immediate requests may expand into a LUI + ADDI pair.
module imm_encoder
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [31:0] in_tmpl,
  input  logic [63:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic        out_last
);

  typedef enum logic [1:0] {IDLE, HOLD, HOLD2} state_t;

  state_t      state_reg;
  logic        out_valid_reg;
  logic [31:0] out_inst_reg;
  logic        out_err_reg;
  logic        out_last_reg;
  logic [31:0] pend_inst_reg;

  logic        accept;
  logic [4:0]  rd;
  logic [63:0] hi_sum;
  logic        li_short;
  logic        li_pair;
  logic [2:0]  pack_fmt;
  logic [31:0] pack_tmpl;
  logic [63:0] pack_imm;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic [31:0] first_inst;
  logic        first_err;
  logic        first_two;
  logic [31:0] addi_inst;

  assign in_ready = (state_reg == IDLE) || (state_reg == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  assign rd        = in_tmpl[11:7];
  assign hi_sum    = in_imm + 64'h800;
  assign li_short  = fits_s(in_imm, 12);
  assign li_pair   = ($signed(in_imm) >= LI_MIN) && ($signed(in_imm) <= LI_MAX);
  assign addi_inst = {in_imm[11:0], rd, 3'b000, rd, OP_ADDI};

  // LI reuses the packer: short values as ADDI (I), long values as LUI (U)
  // fed with the rounded sum so the upper part absorbs the ADDI's sign.
  always_comb begin
    pack_fmt  = in_fmt;
    pack_tmpl = in_tmpl;
    pack_imm  = in_imm;
    if (in_fmt == FMT_LI) begin
      if (li_short) begin
        pack_fmt  = FMT_I;
        pack_tmpl = {12'd0, 5'd0, 3'b000, rd, OP_ADDI};
      end else begin
        pack_fmt  = FMT_U;
        pack_tmpl = {20'd0, rd, OP_LUI};
        pack_imm  = hi_sum;
      end
    end
  end

  imm_fmt_pack u_pack (
    .fmt  (pack_fmt),
    .tmpl (pack_tmpl),
    .imm  (pack_imm),
    .inst (pack_inst),
    .err  (pack_err)
  );

  always_comb begin
    first_inst = pack_inst;
    first_err  = pack_err;
    first_two  = 1'b0;
    if (in_fmt == FMT_LI) begin
      if (li_short) begin
        first_err = 1'b0;
      end else if (li_pair) begin
        first_err = 1'b0;
        first_two = (in_imm[11:0] != 12'd0);
      end else begin
        first_inst = NOP_INST;
        first_err  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      out_inst_reg  <= '0;
      out_err_reg   <= 1'b0;
      out_last_reg  <= 1'b0;
      pend_inst_reg <= '0;
    end else if (accept) begin
      state_reg     <= first_two ? HOLD2 : HOLD;
      out_valid_reg <= 1'b1;
      out_inst_reg  <= first_inst;
      out_err_reg   <= first_err;
      out_last_reg  <= !first_two;
      pend_inst_reg <= addi_inst;
    end else begin
      case (state_reg)
        HOLD: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        HOLD2: begin
          if (out_ready) begin
            state_reg    <= HOLD;
            out_inst_reg <= pend_inst_reg;
            out_err_reg  <= 1'b0;
            out_last_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_reg;
  assign out_inst  = out_inst_reg;
  assign out_err   = out_err_reg;
  assign out_last  = out_last_reg;

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed literal cases plus random
// traffic checked against a beat-list model of the encoding rules.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [31:0] in_tmpl;
  logic [63:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;
  logic        out_last;

  imm_encoder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_tmpl   (in_tmpl),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void cmp(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---- behavioural model: list of beats a request must produce ----
  function automatic logic [31:0] place(logic [63:0] v, int src, int dst, int w);
    logic [63:0] m;
    m = (64'd1 << w) - 64'd1;
    return 32'(((v >> src) & m) << dst);
  endfunction

  function automatic bit fits(logic [63:0] v, int n);
    longint s, lim;
    s   = longint'(v);
    lim = 64'sd1 <<< (n - 1);
    return (s >= -lim) && (s < lim);
  endfunction

  function automatic void push(logic [31:0] i, logic e, logic l);
    beat_t b;
    b.inst = i; b.err = e; b.last = l;
    exp_q.push_back(b);
  endfunction

  function automatic void model(logic [2:0] f, logic [31:0] t, logic [63:0] imm);
    longint      s;
    logic [63:0] rd, hi, lo;
    s  = longint'(imm);
    rd = 64'(t[11:7]);
    case (f)
      3'd0: push((t & 32'h000F_FFFF) | place(imm, 0, 20, 12), !fits(imm, 12), 1'b1);
      3'd1: push((t & 32'h01FF_F07F) | place(imm, 5, 25, 7) | place(imm, 0, 7, 5),
                 !fits(imm, 12), 1'b1);
      3'd2: push((t & 32'h01FF_F07F) | place(imm, 12, 31, 1) | place(imm, 5, 25, 6)
                 | place(imm, 1, 8, 4) | place(imm, 11, 7, 1),
                 !fits(imm, 13) || (imm % 2 != 0), 1'b1);
      3'd3: push((t & 32'h0000_0FFF) | place(imm, 12, 12, 20),
                 !fits(imm, 32) || (imm % 4096 != 0), 1'b1);
      3'd4: push((t & 32'h0000_0FFF) | place(imm, 20, 31, 1) | place(imm, 1, 21, 10)
                 | place(imm, 11, 20, 1) | place(imm, 12, 12, 8),
                 !fits(imm, 21) || (imm % 2 != 0), 1'b1);
      3'd5: begin
        if (fits(imm, 12)) begin
          push(32'((imm % 4096) * 1048576 + rd * 128 + 19), 1'b0, 1'b1);
        end else if (s >= -64'sd2147483648 && s <= 64'sh7FFF_F7FF) begin
          hi = 64'((s + 2048) >>> 12) & 64'hF_FFFF;
          lo = imm % 4096;
          push(32'(hi * 4096 + rd * 128 + 55), 1'b0, lo == 0);
          if (lo != 0) push(32'(lo * 1048576 + rd * 32768 + rd * 128 + 19), 1'b0, 1'b1);
        end else begin
          push(32'h13, 1'b1, 1'b1);
        end
      end
      default: push(32'h13, 1'b1, 1'b1);
    endcase
  endfunction

  // Called at negedge+1 once inputs for the coming edge are settled.
  function automatic void monitor();
    if (reset) begin
      exp_q.delete();
      return;
    end
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        cmp("spurious_beat", {32'd0, out_inst}, 64'hDEAD);
      end else begin
        cmp("model_inst", {32'd0, out_inst}, {32'd0, exp_q[0].inst});
        cmp("model_err",  {63'd0, out_err},  {63'd0, exp_q[0].err});
        cmp("model_last", {63'd0, out_last}, {63'd0, exp_q[0].last});
        if (out_ready) void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      cmp("missing_beat", 64'd0, 64'(exp_q.size()));
    end
    if (in_valid && in_ready) model(in_fmt, in_tmpl, in_imm);
  endfunction

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      #1; monitor(); @(negedge clk);
    end
  endtask

  task automatic send(logic [2:0] f, logic [31:0] t, logic [63:0] imm);
    bit acc = 0;
    in_fmt = f; in_tmpl = t; in_imm = imm; in_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      #1;
      acc = in_ready;
      monitor();
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) cmp("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic lit(string nm, logic [31:0] i, logic e, logic l);
    bit got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (out_valid) begin
        got = 1;
        cmp({nm, "_inst"}, {32'd0, out_inst}, {32'd0, i});
        cmp({nm, "_err"},  {63'd0, out_err},  {63'd0, e});
        cmp({nm, "_last"}, {63'd0, out_last}, {63'd0, l});
      end
      monitor();
      @(negedge clk);
    end
    if (!got) cmp({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  function automatic logic [63:0] rand_imm();
    logic [63:0] v;
    case ($urandom % 6)
      0: v = 64'(longint'($urandom_range(0, 8191)) - 4096);
      1: begin
        v = 64'(longint'($urandom_range(0, 4194303)) - 2097152);
        if ($urandom % 2 == 0) v[0] = 1'b0;
      end
      2: v = 64'(longint'(int'($urandom)));
      3: begin
        case ($urandom % 10)
          0: v = 64'd2047;
          1: v = 64'd2048;
          2: v = -64'd2048;
          3: v = -64'd2049;
          4: v = 64'h7FFF_F7FF;
          5: v = 64'h7FFF_F800;
          6: v = 64'hFFFF_FFFF_8000_0000;
          7: v = 64'hFFFF_FFFF_7FFF_FFFF;
          8: v = 64'h000F_F000;
          default: v = 64'd4096;
        endcase
      end
      4: v = {$urandom, $urandom};
      default: v = 64'(longint'(int'($urandom & 32'hFFFF_F000)));
    endcase
    return v;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fmt = '0; in_tmpl = '0; in_imm = '0;
    out_ready = 1'b0;
    @(negedge clk);
    idle(3);
    reset = 1'b0;
    #1;
    cmp("rst_out_valid", {63'd0, out_valid}, 64'd0);
    cmp("rst_out_inst",  {32'd0, out_inst},  64'd0);
    cmp("rst_out_err",   {63'd0, out_err},   64'd0);
    cmp("rst_out_last",  {63'd0, out_last},  64'd0);
    cmp("rst_in_ready",  {63'd0, in_ready},  64'd1);
    monitor();
    @(negedge clk);

    out_ready = 1'b1;
    send(3'd5, 32'h0000_0280, 64'h1234_5678);
    lit("li_lui", 32'h1234_52B7, 1'b0, 1'b0);
    lit("li_addi", 32'h6782_8293, 1'b0, 1'b1);
    send(3'd5, 32'h0000_0280, 64'h1234_5800);
    lit("li_round_lui", 32'h1234_62B7, 1'b0, 1'b0);
    lit("li_round_addi", 32'h8002_8293, 1'b0, 1'b1);
    send(3'd5, 32'h0000_0080, 64'hFFFF_FFFF_FFFF_FFFF);
    lit("li_short", 32'hFFF0_0093, 1'b0, 1'b1);
    send(3'd5, 32'h0000_0280, 64'h1234_5000);
    lit("li_lo_zero", 32'h1234_52B7, 1'b0, 1'b1);
    send(3'd5, 32'h0000_0280, 64'hFFFF_FFFF_8000_0000);
    lit("li_min", 32'h8000_02B7, 1'b0, 1'b1);
    send(3'd2, 32'h0000_0067, 64'hFFFF_FFFF_FFFF_FFFC);
    lit("sb_neg4", 32'hFE00_0EE7, 1'b0, 1'b1);
    send(3'd2, 32'h0000_0067, 64'd3);
    lit("sb_odd", 32'h0000_0167, 1'b1, 1'b1);
    send(3'd5, 32'h0000_0280, 64'h7FFF_F800);
    lit("li_range", 32'h0000_0013, 1'b1, 1'b1);
    send(3'd3, 32'h0000_0037, 64'h1001);
    lit("u_low_bits", 32'h0000_1037, 1'b1, 1'b1);
    send(3'd7, 32'hFFFF_FFFF, 64'd0);
    lit("reserved", 32'h0000_0013, 1'b1, 1'b1);

    // Stall during an LI pair
    out_ready = 1'b0;
    send(3'd5, 32'h0000_0280, 64'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      #1;
      cmp("stall_inst",  {32'd0, out_inst},  64'h1234_52B7);
      cmp("stall_valid", {63'd0, out_valid}, 64'd1);
      cmp("stall_ready", {63'd0, in_ready},  64'd0);
      monitor();
      @(negedge clk);
    end
    out_ready = 1'b1;
    lit("stall_lui", 32'h1234_52B7, 1'b0, 1'b0);
    #1;
    cmp("stall_addi_next", {32'd0, out_inst}, 64'h6782_8293);
    monitor();
    @(negedge clk);

    // Reset while the ADDI is pending
    out_ready = 1'b0;
    send(3'd5, 32'h0000_0280, 64'h1234_5678);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    cmp("hold2_rst_valid", {63'd0, out_valid}, 64'd0);
    cmp("hold2_rst_ready", {63'd0, in_ready},  64'd1);
    monitor();
    @(negedge clk);
    idle(4);
    #1;
    cmp("hold2_no_addi", {63'd0, out_valid}, 64'd0);
    monitor();
    @(negedge clk);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom % 400 == 0);
      in_valid  = ($urandom % 4 != 0);
      in_fmt    = ($urandom % 3 == 0) ? 3'd5 : 3'($urandom % 8);
      in_tmpl   = $urandom;
      in_imm    = rand_imm();
      out_ready = ($urandom % 4 != 0);
      #1; monitor(); @(negedge clk);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    idle(5);
    cmp("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
# imm_encoder

Immediate encoder: the inverse of the core's immediate sign-extender. Accepts an instruction template plus a 64-bit immediate and a format code, range-checks the value, and packs it into the I/S/SB/U/UJ bit positions of a 32-bit instruction word. A load-immediate mode expands an immediate too wide for one instruction into a LUI + ADDI pair over two output beats. Sits between the test/boot program generator and instruction memory, behind a valid/ready handshake with a registered output.

## Interface
Parameters:
- none; all widths fixed (RV64, 32-bit instructions).

Ports:
- `clk` in 1: clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_fmt` in 3: 0=I, 1=S, 2=SB, 3=U, 4=UJ, 5=LI; 6-7 reserved.
- `in_tmpl` in 32: template with opcode/rd/rs1/rs2/funct3/funct7; immediate bit positions ignored. LI uses only `in_tmpl[11:7]` (rd).
- `in_imm` in 64: immediate as a full two's-complement value.
- `out_valid` out 1: `out_inst` holds a beat.
- `out_ready` in 1: beat consumed when `out_valid && out_ready`.
- `out_inst` out 32: encoded instruction.
- `out_err` out 1: immediate out of range or reserved format; qualifies the same beat.
- `out_last` out 1: final beat of the request.

## Operation
- Range rules, where "fits sN" means `in_imm` equals sign-extension of its low N bits:
  - I, S: fits s12.
  - SB: fits s13 and bit0=0.
  - UJ: fits s21 and bit0=0.
  - U: fits s32 and imm[11:0]=0.
- Failing the rule, or a reserved format, sets `out_err=1`. The packed word is still emitted from the truncated bits (reserved format: `0x00000013`). The request produces exactly one beat.
- Packing, non-immediate bits taken from `in_tmpl`:
  - I: inst[31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - SB: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - UJ: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- LI, with rd=`in_tmpl[11:7]`:
  - Fits s12: one beat, `ADDI rd,x0,imm`.
  - Else if imm in [-2^31, 0x7FFFF7FF]: compute hi=(imm+0x800)>>12 (20 bits) and lo=imm[11:0].
    - Beat 1: `LUI rd,hi`.
    - Beat 2: `ADDI rd,rd,lo`, emitted only when lo≠0.
    - If lo=0, LUI is the only beat and has `out_last=1`.
  - Else: `out_err=1`, one beat `0x00000013`.
- Opcodes: LUI 0110111, ADDI 0010011 (funct3 000).
- FSM states:
  - IDLE: accept a request.
  - HOLD: a beat is held, no second beat pending.
  - HOLD2: LUI is held, ADDI is pending.
- Transitions:
  - IDLE -accept-> HOLD or HOLD2.
  - HOLD -consume, no new accept-> IDLE.
  - HOLD -consume with same-cycle accept-> HOLD or HOLD2.
  - HOLD2 -consume-> HOLD, with the ADDI loaded.
- `in_ready = (state==IDLE) || (state==HOLD && out_ready)`. `in_ready` is 0 in HOLD2.

## Timing
- Latency: accept in cycle N → `out_valid` in N+1.
- Throughput: back-to-back single-beat requests sustain one per cycle when `out_ready`=1. A two-beat LI takes two cycles.
- `out_inst`, `out_err` and `out_last` are registered and stay stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `out_inst=0`, `out_err=0`, `out_last=0`; state=IDLE; `in_ready=1` in the first cycle after reset.
- Reset asserted in HOLD2 drops the pending ADDI. No beat follows reset release.
- `in_*` are ignored when `in_valid=0`, and sampled only on accept.

## Structure
- `imm_pkg`: format enum `imm_fmt_t`, opcode constants `OP_LUI` and `OP_ADDI`, NOP constant `0x00000013`, LI range bounds.
- Sub-module `imm_fmt_pack`: combinational. Takes (fmt, tmpl, imm) and returns (inst, err). The top holds the FSM, the output register, and the LI split using `imm_fmt_pack`.

## Test plan
- LI, rd=5, imm=0x12345678 → beat1 `0x123452B7` with last=0, beat2 `0x67828293` with last=1, err=0.
- LI, rd=5, imm=0x12345800 → `0x123462B7`, then `0x80028293` (lo=-2048, hi rounds up). LI, rd=1, imm=-1 → single beat `0xFFF00093`, last=1.
- SB, tmpl=0x00000067, imm=-4 → `0xFE000EE7`, err=0. Same request with imm=3 → err=1 and a single beat.
- LI imm=0x7FFFF800 → err=1, inst `0x00000013`. U imm=0x1001 → err=1. in_fmt=7 → err=1, inst `0x00000013`.
- Hold `out_ready`=0 for 5 cycles during an LI pair → LUI stable and `in_ready`=0 throughout; releasing gives ADDI in the next cycle.
- Assert reset while in HOLD2 → next cycle `out_valid=0` and `in_ready=1`; the ADDI is never emitted.
